// File: rtl/player_movement_controller_if.sv
// Collision-detector handshake: start pulse out, done level and four neighbour-tile solidity flags back.
// The controller holds master; the detector model or detector block holds slave.
interface player_movement_controller_if;
  logic coll_enable;
  logic coll_done;
  logic coll_left;
  logic coll_right;
  logic coll_up;
  logic coll_down;

  modport master (
    output coll_enable,
    input  coll_done, coll_left, coll_right, coll_up, coll_down
  );

  modport slave (
    input  coll_enable,
    output coll_done, coll_left, coll_right, coll_up, coll_down
  );
endinterface

// File: rtl/player_movement_controller.sv
// Player tile-position stepper: one move/gravity step per accepted tick via the collision handshake.
// Latency 4 cycles plus detector busy time; ticks arriving while busy are dropped and flagged on overrun.
module player_movement_controller #(
  parameter int TILEMAP_LENGTH = 2000,
  parameter int X_START        = 2,
  parameter int Y_START        = 1,
  parameter int JUMP_HEIGHT    = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         tick,
  input  logic                         move_left,
  input  logic                         move_right,
  input  logic                         jump,
  player_movement_controller_if.master coll,
  output logic [10:0]                  x_location,
  output logic [3:0]                   y_location,
  output logic                         busy,
  output logic                         overrun
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_BUSY, WAIT_DONE, UPDATE} state_t;

  localparam logic [10:0] X_MAX     = 11'(TILEMAP_LENGTH - 1);
  localparam logic [10:0] X_RESET   = 11'(X_START);
  localparam logic [3:0]  Y_RESET   = 4'(Y_START);
  localparam logic [2:0]  JUMP_LOAD = 3'(JUMP_HEIGHT);

  state_t      state, state_nxt;
  logic        left_q, right_q, jump_q;
  logic [2:0]  jump_cnt, jump_cnt_nxt, rise_cnt;
  logic [10:0] x_nxt;
  logic [3:0]  y_nxt;
  logic        grounded, jump_start, coll_enable;

  assign coll.coll_enable = coll_enable;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    coll_enable = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (tick) state_nxt = REQ;
      end
      REQ: begin
        coll_enable = 1'b1;
        state_nxt   = WAIT_BUSY;
      end
      // The detector must first be seen leaving idle, otherwise a stale done level would end the step early.
      WAIT_BUSY: if (!coll.coll_done) state_nxt = WAIT_DONE;
      WAIT_DONE: if (coll.coll_done)  state_nxt = UPDATE;
      UPDATE:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    x_nxt = x_location;
    if (left_q && !right_q && !coll.coll_left && (x_location != 11'd0))
      x_nxt = x_location - 11'd1;
    else if (right_q && !left_q && !coll.coll_right && (x_location < X_MAX))
      x_nxt = x_location + 11'd1;
  end

  // A jump start loads the counter and takes its first rising step in the same update.
  always_comb begin
    grounded     = coll.coll_down || (y_location == 4'd0);
    jump_start   = jump_q && grounded && (jump_cnt == 3'd0);
    rise_cnt     = jump_start ? JUMP_LOAD : jump_cnt;
    y_nxt        = y_location;
    jump_cnt_nxt = jump_cnt;
    if (rise_cnt != 3'd0) begin
      if (!coll.coll_up && (y_location != 4'd15)) begin
        y_nxt        = y_location + 4'd1;
        jump_cnt_nxt = rise_cnt - 3'd1;
      end else begin
        jump_cnt_nxt = 3'd0;
      end
    end else if (!coll.coll_down && (y_location != 4'd0)) begin
      y_nxt = y_location - 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_location <= X_RESET;
      y_location <= Y_RESET;
      jump_cnt   <= 3'd0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      jump_q     <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= tick && (state != IDLE);
      if ((state == IDLE) && tick) begin
        left_q  <= move_left;
        right_q <= move_right;
        jump_q  <= jump;
      end
      if (state == UPDATE) begin
        x_location <= x_nxt;
        y_location <= y_nxt;
        jump_cnt   <= jump_cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_player_movement_controller.sv
// Scoreboarded bench: stimulus pushes model positions, a monitor pops them when the DUT finishes a step.
module tb_player_movement_controller;
  localparam int TL = 2000;
  localparam int JH = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        tick, move_left, move_right, jump;
  logic [10:0] x_location;
  logic [3:0]  y_location;
  logic        busy, overrun;

  player_movement_controller_if cif();

  player_movement_controller #(
    .TILEMAP_LENGTH(TL), .X_START(2), .Y_START(1), .JUMP_HEIGHT(JH)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick),
    .move_left(move_left), .move_right(move_right), .jump(jump),
    .coll(cif),
    .x_location(x_location), .y_location(y_location),
    .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  typedef struct { int x; int y; } pos_t;
  pos_t exp_q[$];

  int n_checks = 0, n_fail = 0;
  int ce_cnt = 0, ov_cnt = 0;
  int det_lat_min = 0, det_lat_max = 3;
  int mx = 2, my = 1, mjc = 0;
  bit prev_busy = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the movement rules applied to integer position and remaining-rise count.
  task automatic model_step(input bit l, r, j, cl, cr, cu, cd);
    pos_t p;
    bit   grounded;
    int   rise;
    if (l && !r && !cl && mx > 0)            mx = mx - 1;
    else if (r && !l && !cr && mx < TL - 1)  mx = mx + 1;
    grounded = cd || (my == 0);
    rise = (j && grounded && mjc == 0) ? JH : mjc;
    if (rise > 0) begin
      if (!cu && my < 15) begin my = my + 1; mjc = rise - 1; end
      else mjc = 0;
    end else if (!cd && my > 0) begin
      my = my - 1;
    end
    p.x = mx;
    p.y = my;
    exp_q.push_back(p);
  endtask

  // Detector model: drops done after each start pulse, raises it again a few cycles later.
  initial begin
    cif.coll_done = 1'b1;
    forever begin
      @(negedge clock);
      if (cif.coll_enable) begin
        cif.coll_done = 1'b0;
        repeat (2 + $urandom_range(det_lat_max, det_lat_min)) @(negedge clock);
        cif.coll_done = 1'b1;
      end
    end
  end

  // Monitor: a busy fall outside reset marks a completed step.
  initial begin
    pos_t e;
    forever begin
      @(negedge clock);
      if (cif.coll_enable) ce_cnt++;
      if (overrun) ov_cnt++;
      if (reset) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !busy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_step", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("x_location", int'(x_location), e.x);
            check("y_location", int'(y_location), e.y);
          end
        end
        prev_busy = busy;
      end
    end
  end

  task automatic do_step(input bit l, r, j, cl, cr, cu, cd, input bit ov_tick);
    int t;
    @(negedge clock);
    move_left = l; move_right = r; jump = j;
    cif.coll_left = cl; cif.coll_right = cr; cif.coll_up = cu; cif.coll_down = cd;
    ce_cnt = 0;
    ov_cnt = 0;
    tick = 1'b1;
    model_step(l, r, j, cl, cr, cu, cd);
    @(negedge clock);
    tick = 1'b0;
    check("coll_enable_latency", int'(cif.coll_enable), 1);
    move_left  = 1'($urandom_range(1, 0));
    move_right = 1'($urandom_range(1, 0));
    jump       = 1'($urandom_range(1, 0));
    if (ov_tick) begin
      repeat (3) @(negedge clock);
      tick = 1'b1;
      @(negedge clock);
      tick = 1'b0;
    end
    t = 0;
    while (busy && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (busy) check("step_timeout", 1, 0);
    check("coll_enable_count", ce_cnt, 1);
    check("overrun_count", ov_cnt, ov_tick ? 1 : 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_x"}, int'(x_location), 2);
    check({tag, "_y"}, int'(y_location), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_coll_enable"}, int'(cif.coll_enable), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; move_left = 1'b0; move_right = 1'b0; jump = 1'b0;
    cif.coll_left = 1'b0; cif.coll_right = 1'b0; cif.coll_up = 1'b0; cif.coll_down = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_reset_state("rst");
    ce_cnt = 0;
    repeat (10) @(negedge clock);
    check_reset_state("idle_hold");
    check("idle_coll_enable_pulses", ce_cnt, 0);

    do_step(0, 0, 0, 0, 0, 0, 0, 0);   // fall to the floor
    do_step(0, 1, 0, 0, 0, 0, 0, 0);
    check("right_step_x", int'(x_location), 3);
    check("right_step_y", int'(y_location), 0);
    check("right_step_busy", int'(busy), 0);

    repeat (3) do_step(1, 0, 0, 0, 0, 0, 0, 0);
    do_step(1, 0, 0, 0, 0, 0, 0, 0);
    check("left_edge_x", int'(x_location), 0);
    do_step(1, 1, 0, 0, 0, 0, 0, 0);
    check("both_buttons_x", int'(x_location), 0);

    do_step(0, 0, 1, 0, 0, 0, 0, 0);
    check("jump1_y", int'(y_location), 1);
    do_step(0, 0, 1, 0, 0, 0, 0, 0);
    check("jump2_y", int'(y_location), 2);
    do_step(0, 0, 1, 0, 0, 0, 0, 0);
    check("jump3_y", int'(y_location), 3);
    do_step(0, 0, 0, 0, 0, 0, 0, 0);
    check("jump_fall_y", int'(y_location), 2);
    repeat (2) do_step(0, 0, 0, 0, 0, 0, 0, 0);

    // Climb to y=5 from a platform at y=3, then bump the ceiling.
    repeat (3) do_step(0, 0, 1, 0, 0, 0, 0, 0);
    do_step(0, 0, 1, 0, 0, 0, 1, 0);
    do_step(0, 0, 0, 0, 0, 0, 0, 0);
    check("pre_bump_y", int'(y_location), 5);
    do_step(0, 0, 0, 0, 0, 1, 0, 0);
    check("head_bump_y", int'(y_location), 5);
    do_step(0, 0, 0, 0, 0, 0, 0, 0);
    check("after_bump_y", int'(y_location), 4);

    det_lat_min = 5; det_lat_max = 5;
    do_step(0, 1, 0, 0, 0, 0, 1, 1);
    check("overrun_step_x", int'(x_location), 1);

    // Reset while the detector is still busy abandons the step.
    @(negedge clock);
    move_left = 1'b1; move_right = 1'b0; tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    check_reset_state("mid_reset");
    @(negedge clock);
    reset = 1'b0;
    move_left = 1'b0;
    mx = 2; my = 1; mjc = 0;
    repeat (10) @(negedge clock);
    check_reset_state("post_reset");
    det_lat_min = 0; det_lat_max = 3;
    do_step(0, 1, 0, 0, 0, 0, 0, 0);
    check("fresh_step_x", int'(x_location), 3);

    det_lat_max = 0;
    while (mx < TL - 1) do_step(0, 1, 0, 0, 0, 0, 0, 0);
    do_step(0, 1, 0, 0, 0, 0, 0, 0);
    check("right_edge_x", int'(x_location), TL - 1);
    det_lat_max = 3;

    for (int i = 0; i < 250; i++) begin
      do_step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
              1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
              1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 0);
    end

    repeat (5) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/player_movement_controller.md
PLAYER_MOVEMENT_CONTROLLER -- requirements
Module: player_movement_controller

Interface
REQ-001 SHALL have parameter TILEMAP_LENGTH, default 2000, level width in tiles.
REQ-002 SHALL have parameter X_START, default 2, reset x tile.
REQ-003 SHALL have parameter Y_START, default 1, reset y tile.
REQ-004 SHALL have parameter JUMP_HEIGHT, default 3, tiles risen per jump (1..7).
REQ-005 SHALL have port clock, input, 1, sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port tick, input, 1, one-cycle frame-step pulse.
REQ-008 SHALL have port move_left, input, 1, left button level.
REQ-009 SHALL have port move_right, input, 1, right button level.
REQ-010 SHALL have port jump, input, 1, jump button level.
REQ-011 SHALL have port coll_enable, output, 1, collision-check start pulse to detector.
REQ-012 SHALL have port coll_done, input, 1, detector idle/done level.
REQ-013 SHALL have ports coll_left, coll_right, coll_up, coll_down, input, 1 each, solid tile at x-1, x+1, y+1, y-1 respectively.
REQ-014 SHALL have port x_location, output, 11, player x in tiles.
REQ-015 SHALL have port y_location, output, 4, player y in tiles (0 = bottom row, increasing upward).
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-017 SHALL have port overrun, output, 1, one-cycle pulse when a tick is dropped.

Function
REQ-018 SHALL implement Moore FSM states IDLE, REQ, WAIT_BUSY, WAIT_DONE, UPDATE.
REQ-019 IDLE: tick=1 -> REQ, latching move_left, move_right, jump into internal registers that same edge; else stay.
REQ-020 REQ: coll_enable=1 for exactly this one cycle; next state WAIT_BUSY unconditionally.
REQ-021 WAIT_BUSY: coll_done=0 -> WAIT_DONE; else stay.
REQ-022 WAIT_DONE: coll_done=1 -> UPDATE; else stay.
REQ-023 UPDATE: x, y, jump counter update at the end of this cycle; next state IDLE.
REQ-024 Horizontal rule: latched left and not right, coll_left=0, x>0 -> x-1; latched right and not left, coll_right=0, x<TILEMAP_LENGTH-1 -> x+1; otherwise x unchanged.
REQ-025 Grounded SHALL mean coll_down=1 or y=0.
REQ-026 Jump start: latched jump, grounded, jump counter=0 -> counter loads JUMP_HEIGHT, and the rising step below applies in the same UPDATE.
REQ-027 Rising (counter>0 after REQ-026): coll_up=0 and y<15 -> y+1, counter-1; otherwise counter cleared to 0, y unchanged (head bump/ceiling).
REQ-028 Falling (counter=0, no jump start): coll_down=0 and y>0 -> y-1; else y unchanged.
REQ-029 Horizontal and vertical updates SHALL both apply in the same UPDATE cycle, using flags sampled in that cycle.
REQ-030 tick while busy=1 SHALL be ignored and SHALL pulse overrun for one cycle; tick in IDLE never pulses overrun.
REQ-031 Button changes outside the IDLE->REQ edge SHALL have no effect on the current step.
REQ-032 x arithmetic SHALL be 11-bit unsigned and y 4-bit unsigned; neither SHALL wrap.
REQ-033 Step latency SHALL be 4 cycles plus the detector's busy time: tick in IDLE at cycle 0 gives coll_enable at cycle 1 and new position visible at the cycle after UPDATE.

Reset
REQ-034 reset=1 SHALL immediately force state IDLE, x_location=X_START, y_location=Y_START, jump counter 0, latched buttons 0, coll_enable=0, busy=0, overrun=0.
REQ-035 reset asserted mid-step SHALL abandon the step with no position change; the first tick after release starts a fresh step.

Verification
REQ-036 After reset release: x=2, y=1, busy=0, coll_enable=0; hold all inputs 0 with no tick -> outputs stay constant.
REQ-037 Bench SHALL cover: tick with move_right=1, all flags 0, y=0 -> one coll_enable pulse; after detector done, x=3, y=0, busy drops.
REQ-038 Bench SHALL cover: x=0, move_left=1 -> x stays 0; x=1999, move_right=1 -> x stays 1999; both buttons -> no x change.
REQ-039 Bench SHALL cover: y=0, jump=1, JUMP_HEIGHT=3, coll_up=0 -> over 3 ticks y=1,2,3; 4th tick with coll_down=0 -> y=2.
REQ-040 Bench SHALL cover: rising at y=5 with coll_up=1 -> y stays 5, counter 0; next tick with coll_down=0 -> y=4.
REQ-041 Bench SHALL cover: tick asserted during WAIT_DONE -> overrun pulses once, no extra coll_enable; reset during WAIT_DONE -> x=2, y=1, IDLE.
